// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit:
// state enum, opcode/ALUOp/mux-select constants and the decoded control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC_R = 4'd6,
    RWB    = 4'd7,
    EXEC_I = 4'd8,
    IWB    = 4'd9,
    BEQ    = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_SUB   = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSrc;
    logic       illegalOp;
  } ctrlWord_t;

  // States that stall on the memory handshake
  function automatic logic isMemWait(state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational Moore decode of the current state (plus mem_ready in FETCH)
// into the datapath control word.
//   state    : current FSM state
//   memReady : memory handshake, qualifies IR/PC load in FETCH
//   ctrl     : decoded control word, all-zero for unlisted fields
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t    state,
  input  logic      memReady,
  output ctrlWord_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.aluOp   = ALU_ADD;
        ctrl.pcSrc   = PCSRC_ALU;
        ctrl.irWrite = memReady;
        ctrl.pcWrite = memReady;
      end
      // Branch target precompute while the opcode is decoded
      DECODE: begin
        ctrl.aluSrcB = SRCB_IMM_SH2;
        ctrl.aluOp   = ALU_ADD;
      end
      MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      MEMRD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      MEMWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = 1'b1;
      end
      MEMWR: begin
        ctrl.memWrite = 1'b1;
        ctrl.iorD     = 1'b1;
      end
      EXEC_R: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_RT;
        ctrl.aluOp   = ALU_FUNCT;
      end
      RWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
      end
      EXEC_I: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      IWB: begin
        ctrl.regWrite = 1'b1;
      end
      BEQ: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_RT;
        ctrl.aluOp       = ALU_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSrc       = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pcWrite = 1'b1;
        ctrl.pcSrc   = PCSRC_JUMP;
      end
      TRAP: begin
        ctrl.illegalOp = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready handshake and wait timeout.
//   clk, rst_n      : clock, async active-low reset
//   OpCode          : IR[31:26], looked at only in DECODE and MEMADR
//   mem_ready       : memory completed the current access this cycle
//   PCWrite..PCSrc  : datapath control word
//   illegal_op      : held while trapped
//   mem_timeout     : sticky, memory wait exceeded MEM_WAIT_MAX cycles
//   state_o         : current state encoding
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OpCode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_o
);

  localparam int unsigned WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  state_t            state;
  logic [WAIT_W-1:0] waitCnt;
  logic              waitHit;
  ctrlWord_t         ctrl;

  // This stalled cycle is the MEM_WAIT_MAX-th in a row; mem_ready wins if present
  assign waitHit = (MEM_WAIT_MAX != 0) && isMemWait(state) && !mem_ready
                   && (waitCnt == WAIT_W'(MEM_WAIT_MAX - 1));

  // State register, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      waitCnt     <= '0;
      mem_timeout <= 1'b0;
    end else if (isMemWait(state) && !mem_ready) begin
      if (waitHit) begin
        state       <= TRAP;
        waitCnt     <= '0;
        mem_timeout <= 1'b1;
      end else if (MEM_WAIT_MAX != 0) begin
        waitCnt <= waitCnt + WAIT_W'(1);
      end
    end else begin
      waitCnt <= '0;
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          case (OpCode)
            OP_R:         state <= EXEC_R;
            OP_LW, OP_SW: state <= MEMADR;
            OP_BEQ:       state <= BEQ;
            OP_ADDI:      state <= EXEC_I;
            OP_J:         state <= JUMP;
            default:      state <= TRAP;
          endcase
        end
        MEMADR:  state <= (OpCode == OP_LW) ? MEMRD : MEMWR;
        MEMRD:   state <= MEMWB;
        MEMWB:   state <= FETCH;
        MEMWR:   state <= FETCH;
        EXEC_R:  state <= RWB;
        RWB:     state <= FETCH;
        EXEC_I:  state <= IWB;
        IWB:     state <= FETCH;
        BEQ:     state <= FETCH;
        JUMP:    state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

  mc_ctrl_outdec uOutdec (
    .state    (state),
    .memReady (mem_ready),
    .ctrl     (ctrl)
  );

  // Write enables are forced low while reset is held so FETCH's
  // mem_ready-qualified loads cannot fire during reset
  assign PCWrite     = ctrl.pcWrite     & rst_n;
  assign PCWriteCond = ctrl.pcWriteCond & rst_n;
  assign IRWrite     = ctrl.irWrite     & rst_n;
  assign RegWrite    = ctrl.regWrite    & rst_n;
  assign MemWrite    = ctrl.memWrite    & rst_n;
  assign IorD        = ctrl.iorD;
  assign MemRead     = ctrl.memRead;
  assign MemToReg    = ctrl.memToReg;
  assign RegDst      = ctrl.regDst;
  assign ALUSrcA     = ctrl.aluSrcA;
  assign ALUSrcB     = ctrl.aluSrcB;
  assign ALUOp       = ctrl.aluOp;
  assign PCSrc       = ctrl.pcSrc;
  assign illegal_op  = ctrl.illegalOp;
  assign state_o     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level reference model (state path
// per opcode, memory-stall accounting) driven by directed and random stimulus.
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  localparam int MAXW = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] OpCode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSrc;
  logic       illegal_op, mem_timeout;
  logic [3:0] state_o;
  logic [17:0] dutCtrl;

  int testsRun = 0;
  int testsFailed = 0;

  state_t     mState;
  state_t     mPath[$];
  int         mPos;
  int         mWaits;
  bit         mTimeout;
  logic [5:0] mOp;
  int         trapCycles;

  multicycle_ctrl #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign dutCtrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
                    illegal_op};

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Control word expected in each state, straight from the state descriptions
  function automatic logic [17:0] expCtrl(state_t s, bit rdy);
    logic pcW = 0, pcWC = 0, iorD = 0, mRd = 0, mWr = 0, irW = 0;
    logic m2r = 0, rDst = 0, rW = 0, sA = 0, ill = 0;
    logic [1:0] sB = 2'b00, pSrc = 2'b00;
    logic [2:0] aOp = 3'b000;
    case (s)
      FETCH:  begin mRd = 1; sB = 2'b01; aOp = 3'b001; irW = rdy; pcW = rdy; end
      DECODE: begin sB = 2'b11; aOp = 3'b001; end
      MEMADR: begin sA = 1; sB = 2'b10; aOp = 3'b001; end
      MEMRD:  begin mRd = 1; iorD = 1; end
      MEMWB:  begin rW = 1; m2r = 1; end
      MEMWR:  begin mWr = 1; iorD = 1; end
      EXEC_R: begin sA = 1; sB = 2'b00; aOp = 3'b111; end
      RWB:    begin rW = 1; rDst = 1; end
      EXEC_I: begin sA = 1; sB = 2'b10; aOp = 3'b001; end
      IWB:    begin rW = 1; end
      BEQ:    begin sA = 1; aOp = 3'b000; pcWC = 1; pSrc = 2'b01; end
      JUMP:   begin pcW = 1; pSrc = 2'b10; end
      TRAP:   begin ill = 1; end
      default: ;
    endcase
    return {pcW, pcWC, iorD, mRd, mWr, irW, m2r, rDst, rW, sA, sB, aOp, pSrc, ill};
  endfunction

  // Whole-instruction state path for an opcode
  function automatic void loadPath(input logic [5:0] op);
    mPath = {};
    mPath.push_back(FETCH);
    mPath.push_back(DECODE);
    case (op)
      6'b000000: begin mPath.push_back(EXEC_R); mPath.push_back(RWB); end
      6'b100011: begin mPath.push_back(MEMADR); mPath.push_back(MEMRD); mPath.push_back(MEMWB); end
      6'b101011: begin mPath.push_back(MEMADR); mPath.push_back(MEMWR); end
      6'b000100: mPath.push_back(BEQ);
      6'b001000: begin mPath.push_back(EXEC_I); mPath.push_back(IWB); end
      6'b000010: mPath.push_back(JUMP);
      default:   mPath.push_back(TRAP);
    endcase
    mOp = op;
    mPos = 0;
    mWaits = 0;
    mState = FETCH;
  endfunction

  function automatic logic [5:0] randOp();
    int r = $urandom_range(0, 15);
    if (r < 3)  return 6'b000000;
    if (r < 5)  return 6'b100011;
    if (r < 7)  return 6'b101011;
    if (r < 9)  return 6'b000100;
    if (r < 11) return 6'b001000;
    if (r < 13) return 6'b000010;
    if (r < 15) return 6'($urandom);
    return 6'b111111;
  endfunction

  // Advance the model by one clock given this cycle's mem_ready
  function automatic void modelStep(input bit rdy);
    if (mState == TRAP) begin
      trapCycles++;
    end else if ((mState inside {FETCH, MEMRD, MEMWR}) && !rdy) begin
      mWaits++;
      if (mWaits == MAXW) begin
        mState = TRAP;
        mTimeout = 1'b1;
      end
    end else begin
      mWaits = 0;
      mPos++;
      if (mPos >= mPath.size()) loadPath(randOp());
      else mState = mPath[mPos];
    end
  endfunction

  // Called at posedge+1: drive inputs, check outputs, advance to next posedge+1
  task automatic stepCycle(input bit rdy);
    mem_ready = rdy;
    OpCode = (mState == DECODE || mState == MEMADR) ? mOp : 6'($urandom);
    #1;
    checkVal("state", 32'(state_o), 32'(mState));
    checkVal("ctrl", 32'(dutCtrl), 32'(expCtrl(mState, rdy)));
    checkVal("timeout", 32'(mem_timeout), 32'(mTimeout));
    modelStep(rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    OpCode = 6'($urandom);
    #1;
    checkVal("rst_state", 32'(state_o), 32'(FETCH));
    checkVal("rst_wen", 32'({PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite}), 32'd0);
    checkVal("rst_fetch", 32'({MemRead, IorD}), 32'b10);
    checkVal("rst_flags", 32'({illegal_op, mem_timeout}), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mTimeout = 1'b0;
    trapCycles = 0;
    loadPath(randOp());
  endtask

  // Run one instruction from FETCH and check its total cycle count
  task automatic measure(input logic [5:0] op, input int memLow, input int expN);
    int n = 0;
    int low = 0;
    bit rdy;
    loadPath(op);
    do begin
      rdy = 1'b1;
      if ((mState == MEMRD || mState == MEMWR) && low < memLow) begin
        rdy = 1'b0;
        low++;
      end
      stepCycle(rdy);
      n++;
    end while (state_o != 4'(FETCH) && n < 40);
    checkVal($sformatf("cycles_op%b_w%0d", op, memLow), 32'(n), 32'(expN));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int burst = 0;
    bit rdy;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    OpCode = '0;
    @(posedge clk); #1;
    doReset();

    // Cycle counts with no stalls, then with memory stalls
    measure(6'b000000, 0, 4);
    measure(6'b001000, 0, 4);
    measure(6'b100011, 0, 5);
    measure(6'b101011, 0, 4);
    measure(6'b000100, 0, 3);
    measure(6'b000010, 0, 3);
    measure(6'b100011, 3, 8);
    measure(6'b101011, 2, 6);

    // Reset while stalled in MEMRD
    loadPath(6'b100011);
    repeat (3) stepCycle(1'b1);
    stepCycle(1'b0);
    checkVal("in_memrd", 32'(state_o), 32'(MEMRD));
    doReset();
    measure(6'b000000, 0, 4);

    // Unknown opcode traps and stays inert
    loadPath(6'b111111);
    repeat (23) stepCycle(1'($urandom));
    checkVal("illegal_held", 32'(illegal_op), 32'd1);
    doReset();

    // FETCH stall hits the limit
    loadPath(6'b000000);
    repeat (MAXW) stepCycle(1'b0);
    checkVal("to_state", 32'(state_o), 32'(TRAP));
    checkVal("to_flag", 32'(mem_timeout), 32'd1);
    repeat (3) stepCycle(1'($urandom));
    doReset();

    // mem_ready on the last permitted cycle still completes normally
    loadPath(6'b000000);
    repeat (MAXW - 1) stepCycle(1'b0);
    stepCycle(1'b1);
    checkVal("edge_state", 32'(state_o), 32'(DECODE));
    checkVal("edge_flag", 32'(mem_timeout), 32'd0);
    repeat (3) stepCycle(1'b1);

    // MEMWR stall hits the limit
    loadPath(6'b101011);
    repeat (3) stepCycle(1'b1);
    repeat (MAXW) stepCycle(1'b0);
    checkVal("to_wr_state", 32'(state_o), 32'(TRAP));
    doReset();

    // Random instruction stream with stall bursts and occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ((mState == TRAP && trapCycles > 4) || $urandom_range(0, 299) == 0) begin
        doReset();
      end else begin
        if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(4, 20);
        if (burst > 0) begin
          rdy = 1'b0;
          burst--;
        end else begin
          rdy = ($urandom_range(0, 3) != 0);
        end
        stepCycle(rdy);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore FSM that sequences the multi-cycle MIPS datapath: PC, IR, register file, ALU and unified instruction/data memory. Replaces the single-cycle opcode decoder for the multi-cycle build. Handles R-type, lw, sw, beq, addi and j, with a memory-ready handshake. Unknown opcodes trap.

Parameters:
MEM_WAIT_MAX, 15, cycles a memory state waits for mem_ready before raising mem_timeout; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
OpCode  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory has completed the current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load qualified by ALU zero (beq)
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  IR load
MemToReg  out  1  write-back source: 1=MDR, 0=ALUOut
RegDst  out  1  destination register: 1=rd, 0=rt
RegWrite  out  1  register-file write
ALUSrcA  out  1  0=PC, 1=rs
ALUSrcB  out  2  00=rt, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
ALUOp  out  3  ALU control class
PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
illegal_op  out  1  sticky trap flag
mem_timeout  out  1  sticky memory-wait timeout flag
state_o  out  4  current state encoding, for debug and coverage

Behaviour:
- State register and the wait counter reset asynchronously to FETCH and 0. Sticky flags reset to 0. All outputs are decoded from state, plus mem_ready where noted.
- Any output not listed for a state is 0. There are no X outputs.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSrc=00.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH while !mem_ready, else go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (precomputes the branch target). Next state by OpCode:
  - 000000 -> EXEC_R
  - 100011 or 101011 -> MEMADR
  - 000100 -> BEQ
  - 001000 -> EXEC_I
  - 000010 -> JUMP
  - any other opcode -> TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Go to MEMRD if lw, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, MemToReg=1, RegDst=0. Then FETCH.
- MEMWR: MemWrite=1, IorD=1. Wait for mem_ready, then FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=FUNCT. Then RWB.
- RWB: RegWrite=1, RegDst=1, MemToReg=0. Then FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Then IWB.
- IWB: RegWrite=1, RegDst=0, MemToReg=0. Then FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSrc=01. Then FETCH.
- JUMP: PCWrite=1, PCSrc=10. Then FETCH.
- TRAP: illegal_op=1. Stays in TRAP until reset; all write enables are 0.
- OpCode is sampled only in DECODE and MEMADR; changes in other states are ignored.
- Cycle counts with mem_ready tied high:
  - R-type / addi: 4
  - lw: 5
  - sw: 4
  - beq / j: 3
- Wait counter:
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with !mem_ready; clears on any state change.
  - When it reaches MEM_WAIT_MAX (and MEM_WAIT_MAX != 0), set mem_timeout and go to TRAP.
  - mem_ready in the same cycle the counter reaches the limit takes priority: normal transition, no timeout.
- Reset asserted mid-instruction: immediate return to FETCH with outputs as specified for FETCH. No write enable may glitch high because of reset.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (4-bit)
  - opcode constants: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010
  - ALUOp constants: SUB=3'b000, ADD=3'b001, FUNCT=3'b111
  - ALUSrcB and PCSrc encodings
- One sub-module: mc_ctrl_outdec, a purely combinational state(+mem_ready) -> control-word decode. The FSM and wait counter stay in the top module.

Test Plan:
- rst_n low mid-MEMRD, then high -> state_o=FETCH, MemRead=1, IorD=0; RegWrite=MemWrite=PCWrite=0 while rst_n low.
- mem_ready=1, OpCode=000000 -> state sequence FETCH, DECODE, EXEC_R, RWB, FETCH; RegWrite=1 and RegDst=1 only in cycle 4; ALUOp=111 in EXEC_R.
- OpCode=100011, mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles; MemWB follows with RegWrite=1, MemToReg=1; lw total 8 cycles.
- OpCode=000100 then 000010 -> BEQ asserts PCWriteCond=1, PCSrc=01, ALUOp=000; JUMP asserts PCWrite=1, PCSrc=10; each instruction takes 3 cycles.
- OpCode=111111 in DECODE -> TRAP next cycle, illegal_op=1 held; no write enable asserted for 20 cycles.
- MEM_WAIT_MAX=15, mem_ready stuck low in FETCH -> mem_timeout=1 and TRAP after 15 waiting cycles; mem_ready=1 on the 15th waiting cycle -> DECODE and no timeout.
